// File: rtl/mem_pkg.sv
// Shared types and geometry helpers for the memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Width of the access-latency wait counter (LATENCY up to 15).
    localparam int unsigned CntW = 4;

    function automatic int unsigned line_bytes(input int unsigned words, input int unsigned bitsize);
        return (words * bitsize) / 8;
    endfunction

    function automatic int unsigned off_width(input int unsigned words, input int unsigned bitsize);
        return $clog2(line_bytes(words, bitsize));
    endfunction

    function automatic int unsigned idx_width(input int unsigned mem_size);
        return $clog2(mem_size);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Line storage: one synchronous write port and one registered read port.
module mem_responder_array
    import mem_pkg::*;
#(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 1024,
    localparam int unsigned IdxW = idx_width(Depth)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IdxW-1:0]  waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic             rd_clr_i,
    input  logic [IdxW-1:0]  raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_d, rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_clr_i) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory endpoint: one load/store at a time, one-cycle completion pulse.
// Optional MEM_RESPONDER_ERR_EN flags out-of-range addresses on mem_err_o instead of wrapping.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned BITSIZE          = 32,
    parameter int unsigned N_WORDS_PER_ADDR = 4,
    parameter int unsigned MEM_SIZE         = 1024,
    parameter int unsigned LATENCY          = 2,
    localparam int unsigned W               = N_WORDS_PER_ADDR * BITSIZE
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [31:0]   mem_addr_i,
    input  logic [W-1:0]  mem_data_i,
    input  logic          mem_store_i,
    input  logic          mem_valid_i,
    output logic [W-1:0]  mem_data_o,
    output logic          mem_valid_o
`ifdef MEM_RESPONDER_ERR_EN
    ,
    output logic          mem_err_o
`endif
);

    localparam int unsigned OffW = off_width(N_WORDS_PER_ADDR, BITSIZE);
    localparam int unsigned IdxW = idx_width(MEM_SIZE);

    state_e            state_d, state_q;
    logic [CntW-1:0]   cnt_d, cnt_q;
    logic [IdxW-1:0]   idx_d, idx_q;
    logic              store_d, store_q;
    logic [W-1:0]      wdata_d, wdata_q;
    logic              commit;
    logic              err_cur;

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic [32:0] AddrLimit = 33'(MEM_SIZE * line_bytes(N_WORDS_PER_ADDR, BITSIZE));
    logic err_d, err_q;
    logic addr_oob;

    assign addr_oob = ({1'b0, mem_addr_i} >= AddrLimit);
    assign err_cur  = err_q;
    assign mem_err_o = (state_q == StResp) && err_q;
`else
    logic unused_addr;

    // Upper address bits are intentionally dropped so addresses alias.
    assign unused_addr = ^mem_addr_i;
    assign err_cur     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        store_d = store_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (mem_valid_i) begin
                    idx_d   = mem_addr_i[OffW +: IdxW];
                    store_d = mem_store_i;
                    wdata_d = mem_data_i;
                    cnt_d   = CntW'(LATENCY - 1);
`ifdef MEM_RESPONDER_ERR_EN
                    err_d   = addr_oob;
`endif
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!mem_valid_i) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            store_q <= 1'b0;
            wdata_q <= '0;
`ifdef MEM_RESPONDER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
`ifdef MEM_RESPONDER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Reset on the commit edge must win over the array write.
    mem_responder_array #(
        .Width (W),
        .Depth (MEM_SIZE)
    ) u_array (
        .clk      (clk),
        .rst_i    (rst_i),
        .we_i     (commit && store_q && !err_cur && !rst_i),
        .waddr_i  (idx_q),
        .wdata_i  (wdata_q),
        .re_i     (commit && !store_q && !err_cur),
        .rd_clr_i (commit && !store_q && err_cur),
        .raddr_i  (idx_q),
        .rdata_o  (mem_data_o)
    );

    assign mem_valid_o = (state_q == StResp);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expectations, monitor checks responses.
module tb_mem_responder;

    localparam int unsigned Lat = 2;
    localparam int unsigned W   = 128;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [31:0]   mem_addr_i = '0;
    logic [W-1:0]  mem_data_i = '0;
    logic          mem_store_i = 1'b0;
    logic          mem_valid_i = 1'b0;
    logic [W-1:0]  mem_data_o;
    logic          mem_valid_o;
`ifdef MEM_RESPONDER_ERR_EN
    logic          mem_err_o;
`endif

    mem_responder #(
        .BITSIZE          (32),
        .N_WORDS_PER_ADDR (4),
        .MEM_SIZE         (1024),
        .LATENCY          (Lat)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_store_i (mem_store_i),
        .mem_valid_i (mem_valid_i),
        .mem_data_o  (mem_data_o),
        .mem_valid_o (mem_valid_o)
`ifdef MEM_RESPONDER_ERR_EN
        ,
        .mem_err_o   (mem_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_rd = '0;
    logic         prev_valid = 1'b0;

    localparam logic [W-1:0] L5   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [W-1:0] L1   = 128'h0101A0A0_0101B0B0_0101C0C0_0101D0D0;
    localparam logic [W-1:0] L8   = 128'h80808080_81818181_82828282_83838383;
    localparam logic [W-1:0] L12  = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [W-1:0] L17  = 128'h17171717_27272727_37373737_47474747;
    localparam logic [W-1:0] DEAD = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [W-1:0] NEWV = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam logic [W-1:0] VA   = 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555;
    localparam logic [W-1:0] VB   = 128'hBBBB6666_BBBB6666_BBBB6666_BBBB6666;

    // Monitor: sample on the falling edge, pop one expectation per completion pulse.
    always @(negedge clk) begin
        if (prev_valid) begin
            checks++;
            if (mem_valid_o) begin
                errors++;
                $display("FAIL pulse_width: mem_valid_o=%0b required 0", mem_valid_o);
            end
        end
        if (mem_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: mem_valid_o=1 with no request outstanding");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (mem_data_o !== e.data) begin
                    errors++;
                    $display("FAIL %s data: got %h required %h", e.name, mem_data_o, e.data);
                end
`ifdef MEM_RESPONDER_ERR_EN
                checks++;
                if (mem_err_o !== e.err) begin
                    errors++;
                    $display("FAIL %s err: got %0b required %0b", e.name, mem_err_o, e.err);
                end
`endif
            end
        end
        prev_valid <= mem_valid_o;
    end

    task automatic issue(input logic [31:0] addr, input logic [W-1:0] data, input logic store,
                         input logic [W-1:0] exp_data, input logic exp_err, input string name,
                         input logic churn, input logic [31:0] c_addr, input logic [W-1:0] c_data);
        bit seen = 0;
        @(posedge clk); #1;
        mem_addr_i  = addr;
        mem_data_i  = data;
        mem_store_i = store;
        mem_valid_i = 1'b1;
        exp_q.push_back('{data: exp_data, err: exp_err, name: name});
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (n == 1 && churn) begin
                mem_addr_i  = c_addr;
                mem_data_i  = c_data;
                mem_store_i = ~store;
            end
            if (mem_valid_o) begin
                seen = 1;
                checks++;
                if (n != Lat + 1) begin
                    errors++;
                    $display("FAIL %s latency: got cycle %0d required %0d", name, n, Lat + 1);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no mem_valid_o within 40 cycles", name);
        end
        mem_valid_i = 1'b0;
    endtask

    task automatic st(input logic [31:0] addr, input logic [W-1:0] data, input string name);
        issue(addr, data, 1'b1, last_rd, 1'b0, name, 1'b0, '0, '0);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [W-1:0] exp, input logic err,
                      input string name);
        issue(addr, '0, 1'b0, exp, err, name, 1'b0, '0, '0);
        last_rd = exp;
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        bit seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (mem_valid_o) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s: mem_valid_o=1 required 0", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b required 0", mem_valid_o);
        end
        checks++;
        if (mem_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", mem_data_o);
        end

        // Populate lines used later.
        st(32'h50,  L5,  "pre_l5");
        st(32'h10,  L1,  "pre_l1");
        st(32'h80,  L8,  "pre_l8");
        st(32'hC0,  L12, "pre_l12");
        st(32'h110, L17, "pre_l17");

        ld(32'h50, L5, 1'b0, "load_l5");
        ld(32'h5C, L5, 1'b0, "load_l5_offset");

        st(32'h40, DEAD, "store_40");
        ld(32'h40, DEAD, 1'b0, "load_40");

        // Abort: drop valid in cycle 1.
        @(posedge clk); #1;
        mem_addr_i = 32'h80; mem_data_i = NEWV; mem_store_i = 1'b1; mem_valid_i = 1'b1;
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        expect_quiet(6, "abort_no_resp");
        ld(32'h80, L8, 1'b0, "load_after_abort");

        // Reset in cycle 2 of a store, coincident with the commit edge.
        @(posedge clk); #1;
        mem_addr_i = 32'hC0; mem_data_i = NEWV; mem_store_i = 1'b1; mem_valid_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got %0b required 0", mem_valid_o);
        end
        checks++;
        if (mem_data_o !== '0) begin
            errors++;
            $display("FAIL midrst_data: got %h required 0", mem_data_o);
        end
        rst_i = 1'b0;
        mem_valid_i = 1'b0;
        last_rd = '0;
        ld(32'hC0, L12, 1'b0, "load_after_rst");

        // Churn inputs during BUSY; latched values must be used.
        issue(32'h100, VA, 1'b1, last_rd, 1'b0, "churn_store", 1'b1, 32'h110, VB);
        ld(32'h100, VA, 1'b0, "churn_load_100");
        ld(32'h110, L17, 1'b0, "churn_load_110");

`ifdef MEM_RESPONDER_ERR_EN
        ld(32'h4010, '0, 1'b1, "oob_load");
`else
        ld(32'h4010, L1, 1'b0, "wrap_load");
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the memory request interface driven by the memory controller.
- Holds a line-organised storage array and accepts one load or store at a time.
- Models a fixed access latency and returns a one-cycle completion pulse with read data.
- Serves as the main memory for simulation and FPGA builds, and as the protocol reference for future external-memory bridges.

Parameters:
- BITSIZE, 32, bits per word.
- N_WORDS_PER_ADDR, 4, words per line; line width W = N_WORDS_PER_ADDR*BITSIZE.
- MEM_SIZE, 1024, number of lines; must be a power of two.
- LATENCY, 2, wait cycles between request acceptance and array commit; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mem_addr_i  in  32  byte address of the request.
- mem_data_i  in  W  store data from the controller.
- mem_store_i  in  1  1 = store, 0 = load; qualified by mem_valid_i.
- mem_valid_i  in  1  request valid; held high by the controller until completion.
- mem_data_o  out  W  read data, registered.
- mem_valid_o  out  1  completion pulse, one cycle per request.

Behaviour:
- Line index = mem_addr_i[log2(LINE_BYTES) +: log2(MEM_SIZE)], with LINE_BYTES = W/8. Low offset bits are ignored.
- Reset:
  - state = IDLE, mem_valid_o = 0, mem_data_o = 0, wait counter = 0.
  - Array contents are not reset.
- IDLE:
  - If mem_valid_i = 1, latch index, mem_store_i and mem_data_i.
  - Load counter with LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If mem_valid_i = 0, the request is aborted: go to IDLE, with no array write, no response and mem_data_o unchanged.
  - Else if counter != 0, decrement the counter.
  - Else commit:
    - store: write the latched data to array[index].
    - load: mem_data_o <= array[index].
    - Go to RESP.
- RESP:
  - mem_valid_o = 1 for exactly this cycle; go to IDLE unconditionally.
- Latency: a request accepted in cycle 0 produces mem_valid_o in cycle LATENCY+1. With LATENCY = 2, busy cycles are 1 and 2 and the response is in cycle 3.
- Input changes while in BUSY (address, data, store) are ignored because the latched values are used. Only deassertion of mem_valid_i is observed, as an abort.
- In the cycle after RESP the state is IDLE. A still-high mem_valid_i is accepted as a new request, so back-to-back requests can run at one per LATENCY+2 cycles.
- A store leaves mem_data_o unchanged.
- A load that follows a store to the same line sees the stored data.
- Reset in BUSY before the commit edge drops the access. Reset coincident with the commit edge takes priority, so no write occurs.
- Address bits above the index field are ignored, so out-of-range addresses alias (wrap). Exception: when MEM_RESPONDER_ERR_EN is defined.

Optional Feature:
- MEM_RESPONDER_ERR_EN defined:
  - Adds output mem_err_o (1 bit), reset value 0.
  - A request whose mem_addr_i >= MEM_SIZE*LINE_BYTES is still timed normally.
  - At commit it suppresses the array write, or forces mem_data_o to 0 on a load.
  - mem_err_o = 1 in the RESP cycle alongside mem_valid_o, and 0 otherwise.
- Undefined: no mem_err_o port; addresses wrap as described above.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the localparam-style functions for LINE_BYTES, offset width and index width;
  - the counter width constant (4 bits).
- Sub-module mem_responder_array: MEM_SIZE x W array with synchronous write and registered read (one write port, one read port). The responder FSM drives it.

Test Plan:
- Load after reset, LATENCY = 2: preload line 5 = 0x11112222_33334444_55556666_77778888; hold addr 0x50, valid = 1, store = 0 -> mem_valid_o high only in cycle 3; mem_data_o = the preloaded value from cycle 3 onward.
- Store then load: store 0xDEADBEEF_... to addr 0x40, then load addr 0x40 as the next request -> the load returns the stored line; each request's mem_valid_o is a single-cycle pulse; the second request is accepted in the cycle after the first RESP.
- Abort: store to 0x80 with valid dropped in cycle 1 -> no mem_valid_o; a following load of 0x80 returns the old contents.
- Reset mid-access: assert rst_i in cycle 2 of a store to 0xC0 -> mem_valid_o and mem_data_o = 0 next cycle; line 12 unchanged.
- Input churn: change mem_addr_i and mem_data_i during BUSY -> the access uses the values latched in cycle 0.
- Wrap / error: load addr MEM_SIZE*16 + 0x10 -> without the macro, returns line 1; with MEM_RESPONDER_ERR_EN, mem_err_o = 1 and mem_data_o = 0 in the RESP cycle.
